// File: rtl/vec3_packer.sv
// Packs three WIDTH-bit words into one {c,b,a} vector; flush emits a zero-padded partial vector.
// Ports: clk_i/rst_ni, word in (enq/flush handshakes), vector out (enq handshake), count_o drained vectors.
module vec3_packer #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_enq_ena_i,
  input  logic [WIDTH-1:0]     in_enq_v_i,
  output logic                 in_enq_rdy_o,
  input  logic                 in_flush_ena_i,
  output logic                 in_flush_rdy_o,
  output logic                 out_enq_ena_o,
  output logic [3*WIDTH-1:0]   out_enq_v_o,
  input  logic                 out_enq_rdy_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     hold_a_q, hold_a_d;
  logic [WIDTH-1:0]     hold_b_q, hold_b_d;
  logic                 out_valid_q, out_valid_d;
  logic [3*WIDTH-1:0]   out_reg_q, out_reg_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic drain, slot_free, word, flush, emit;
  logic [WIDTH-1:0] lane_a, lane_b, lane_c;

  assign drain     = out_valid_q & out_enq_rdy_i;
  assign slot_free = !out_valid_q | out_enq_rdy_i;

  assign in_enq_rdy_o   = (cnt_q != 2'd2) | slot_free;
  assign in_flush_rdy_o = slot_free;
  assign out_enq_ena_o  = out_valid_q;
  assign out_enq_v_o    = out_reg_q;
  assign count_o        = count_q;

  assign word  = in_enq_ena_i & in_enq_rdy_o;
  assign flush = in_flush_ena_i & in_flush_rdy_o;
  // An empty flush with no word emits nothing.
  assign emit  = (word & (cnt_q == 2'd2))
               | (flush & (word | (cnt_q != 2'd0)));

  // Lanes past the fill point are zero, so partial vectors are padded.
  always_comb begin
    lane_a = hold_a_q;
    lane_b = '0;
    lane_c = '0;
    unique case (cnt_q)
      2'd0: begin
        if (word) lane_a = in_enq_v_i;
      end
      2'd1: begin
        if (word) lane_b = in_enq_v_i;
      end
      2'd2: begin
        lane_b = hold_b_q;
        if (word) lane_c = in_enq_v_i;
      end
      default: begin
        lane_a = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    out_valid_d = out_valid_q;
    out_reg_d   = out_reg_q;
    count_d     = count_q;
    if (drain) begin
      out_valid_d = 1'b0;
      count_d     = count_q + 1'b1;
    end
    if (word) begin
      unique case (cnt_q)
        2'd0:    hold_a_d = in_enq_v_i;
        2'd1:    hold_b_d = in_enq_v_i;
        default: hold_a_d = hold_a_q;
      endcase
      cnt_d = cnt_q + 2'd1;
    end
    if (emit) begin
      out_reg_d   = {lane_c, lane_b, lane_a};
      out_valid_d = 1'b1;
      cnt_d       = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= 2'd0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      out_valid_q <= 1'b0;
      out_reg_q   <= '0;
      count_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      out_valid_q <= out_valid_d;
      out_reg_q   <= out_reg_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_vec3_packer.sv
// Self-checking bench for vec3_packer.
// Directed tasks per feature plus a randomised scoreboard pass.
module tb_vec3_packer;

  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic [W-1:0]  v;
  logic          enq_rdy;
  logic          fena;
  logic          flush_rdy;
  logic          out_ena;
  logic [3*W-1:0] out_v;
  logic          ordy;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  vec3_packer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_enq_ena_i   (ena),
    .in_enq_v_i     (v),
    .in_enq_rdy_o   (enq_rdy),
    .in_flush_ena_i (fena),
    .in_flush_rdy_o (flush_rdy),
    .out_enq_ena_o  (out_ena),
    .out_enq_v_o    (out_v),
    .out_enq_rdy_i  (ordy),
    .count_o        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ena   = 1'b0;
    fena  = 1'b0;
    v     = '0;
    ordy  = 1'b1;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    ena   = 1'b0;
    fena  = 1'b0;
    v     = '0;
    ordy  = 1'b0;
    rst_n = 1'b0;
    cyc();
    checks += 5;
    if (out_ena !== 1'b0) begin
      failures++;
      $display("FAIL reset_ena got=%b exp=0", out_ena);
    end
    if (out_v !== '0) begin
      failures++;
      $display("FAIL reset_v got=%h exp=0", out_v);
    end
    if (count !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", count);
    end
    if (enq_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_enq_rdy got=%b exp=1", enq_rdy);
    end
    if (flush_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_flush_rdy got=%b exp=1", flush_rdy);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    do_reset();
    ordy = 1'b1;
    ena  = 1'b1;
    v    = 32'h11;
    cyc();
    v = 32'h22;
    cyc();
    v = 32'h33;
    cyc();
    ena = 1'b0;
    checks += 2;
    if (out_ena !== 1'b1) begin
      failures++;
      $display("FAIL basic_ena got=%b exp=1", out_ena);
    end
    if (out_v !== {32'h33, 32'h22, 32'h11}) begin
      failures++;
      $display("FAIL basic_v got=%h exp=%h", out_v,
               {32'h33, 32'h22, 32'h11});
    end
    cyc();
    checks += 2;
    if (count !== 6'd1) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=1", count);
    end
    if (out_ena !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got=%b exp=0", out_ena);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ordy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      ena = 1'b1;
      v   = W'(i);
      #1;
      checks++;
      if (enq_rdy !== 1'b1) begin
        failures++;
        $display("FAIL bp_accept%0d got=%b exp=1", i, enq_rdy);
      end
      cyc();
    end
    v = 32'd6;
    #1;
    checks += 4;
    if (enq_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall got=%b exp=0", enq_rdy);
    end
    if (flush_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_flush_stall got=%b exp=0", flush_rdy);
    end
    if (out_ena !== 1'b1) begin
      failures++;
      $display("FAIL bp_valid got=%b exp=1", out_ena);
    end
    if (out_v !== {32'd3, 32'd2, 32'd1}) begin
      failures++;
      $display("FAIL bp_v1 got=%h exp=%h", out_v, {32'd3, 32'd2, 32'd1});
    end
    cyc();
    ordy = 1'b1;
    #1;
    checks++;
    if (enq_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got=%b exp=1", enq_rdy);
    end
    cyc();
    ena = 1'b0;
    checks += 3;
    if (out_ena !== 1'b1) begin
      failures++;
      $display("FAIL bp_ena2 got=%b exp=1", out_ena);
    end
    if (out_v !== {32'd6, 32'd5, 32'd4}) begin
      failures++;
      $display("FAIL bp_v2 got=%h exp=%h", out_v, {32'd6, 32'd5, 32'd4});
    end
    if (count !== 6'd1) begin
      failures++;
      $display("FAIL bp_count1 got=%0d exp=1", count);
    end
    cyc();
    checks++;
    if (count !== 6'd2) begin
      failures++;
      $display("FAIL bp_count2 got=%0d exp=2", count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    ordy = 1'b1;
    ena  = 1'b1;
    v    = 32'hAA;
    cyc();
    ena  = 1'b0;
    fena = 1'b1;
    cyc();
    fena = 1'b0;
    checks += 2;
    if (out_ena !== 1'b1) begin
      failures++;
      $display("FAIL flush1_ena got=%b exp=1", out_ena);
    end
    if (out_v !== {64'd0, 32'hAA}) begin
      failures++;
      $display("FAIL flush1_v got=%h exp=%h", out_v, {64'd0, 32'hAA});
    end
    cyc();
    fena = 1'b1;
    cyc();
    fena = 1'b0;
    checks++;
    if (out_ena !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty_ena got=%b exp=0", out_ena);
    end
    cyc();
    checks++;
    if (count !== 6'd1) begin
      failures++;
      $display("FAIL flush_empty_count got=%0d exp=1", count);
    end
    ena = 1'b1;
    v   = 32'h77;
    cyc();
    v    = 32'h1;
    fena = 1'b1;
    cyc();
    ena  = 1'b0;
    fena = 1'b0;
    checks++;
    if (out_v !== {32'd0, 32'h1, 32'h77}) begin
      failures++;
      $display("FAIL flush_word_v got=%h exp=%h", out_v,
               {32'd0, 32'h1, 32'h77});
    end
    cyc();
    ena  = 1'b1;
    fena = 1'b1;
    v    = 32'h5A;
    cyc();
    ena  = 1'b0;
    fena = 1'b0;
    checks += 2;
    if (out_v !== {64'd0, 32'h5A}) begin
      failures++;
      $display("FAIL flush_word0_v got=%h exp=%h", out_v, {64'd0, 32'h5A});
    end
    if (count !== 6'd2) begin
      failures++;
      $display("FAIL flush_count got=%0d exp=2", count);
    end
  endtask

  task automatic test_stream();
    logic [3*W-1:0] exp;
    do_reset();
    ordy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ena = 1'b1;
      v   = W'(i + 1);
      #1;
      checks++;
      if (enq_rdy !== 1'b1) begin
        failures++;
        $display("FAIL stream_rdy word=%0d got=%b exp=1", i, enq_rdy);
      end
      cyc();
      if (i % 3 == 2) begin
        exp = {W'(i + 1), W'(i), W'(i - 1)};
        checks++;
        if (out_ena !== 1'b1 || out_v !== exp) begin
          failures++;
          $display("FAIL stream_vec word=%0d got=%b/%h exp=1/%h",
                   i, out_ena, out_v, exp);
        end
      end
    end
    ena = 1'b0;
    cyc();
    checks += 2;
    if (count !== 6'd36) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=36", count);
    end
    if (out_ena !== 1'b0) begin
      failures++;
      $display("FAIL stream_idle got=%b exp=0", out_ena);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ordy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      ena = 1'b1;
      v   = W'(i);
      cyc();
    end
    ena = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_ena !== 1'b0) begin
      failures++;
      $display("FAIL areset_ena got=%b exp=0", out_ena);
    end
    if (out_v !== '0) begin
      failures++;
      $display("FAIL areset_v got=%h exp=0", out_v);
    end
    if (count !== '0) begin
      failures++;
      $display("FAIL areset_count got=%0d exp=0", count);
    end
    cyc();
    rst_n = 1'b1;
    ordy  = 1'b1;
    cyc();
    for (int i = 7; i <= 9; i++) begin
      ena = 1'b1;
      v   = W'(i);
      cyc();
    end
    ena = 1'b0;
    checks++;
    if (out_ena !== 1'b1 || out_v !== {32'd9, 32'd8, 32'd7}) begin
      failures++;
      $display("FAIL areset_clean got=%b/%h exp=1/%h", out_ena, out_v,
               {32'd9, 32'd8, 32'd7});
    end
  endtask

  task automatic test_random();
    logic [3*W-1:0] exp_q[$];
    logic [W-1:0]   lanes[$];
    logic [3*W-1:0] pv;
    logic           r0, f0;
    int             drained;
    do_reset();
    drained = 0;
    for (int c = 0; c < 400 + 10; c++) begin
      ordy = ($urandom_range(1) == 1) || (c >= 400);
      ena  = 1'b0;
      fena = 1'b0;
      v    = $urandom;
      #1;
      r0 = enq_rdy;
      f0 = flush_rdy;
      if (c < 400) begin
        ena  = ($urandom_range(9) < 7);
        fena = ($urandom_range(9) < 2);
      end
      #1;
      checks++;
      if (enq_rdy !== r0 || flush_rdy !== f0) begin
        failures++;
        $display("FAIL rnd_rdy_indep cyc=%0d got=%b%b exp=%b%b",
                 c, enq_rdy, flush_rdy, r0, f0);
      end
      if (out_ena && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra cyc=%0d got=%h exp=none", c, out_v);
        end else begin
          pv = exp_q.pop_front();
          if (out_v !== pv) begin
            failures++;
            $display("FAIL rnd_vec cyc=%0d got=%h exp=%h", c, out_v, pv);
          end
        end
        drained++;
      end
      if (ena && enq_rdy) lanes.push_back(v);
      if ((fena && flush_rdy && lanes.size() > 0) || lanes.size() == 3) begin
        while (lanes.size() < 3) lanes.push_back('0);
        exp_q.push_back({lanes[2], lanes[1], lanes[0]});
        lanes.delete();
      end
      cyc();
    end
    checks += 2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_left got=%0d exp=0", exp_q.size());
    end
    if (count !== CW'(drained)) begin
      failures++;
      $display("FAIL rnd_count got=%0d exp=%0d", count, CW'(drained));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_stream();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
